// File: rtl/term_char_writer_if.sv
// Byte-stream input and character-buffer write port of term_char_writer.
//   in_valid/in_char/in_ready  : ASCII byte handshake (source -> writer)
//   w_h_addr/w_v_addr/w_data/w_en : character buffer write port (writer -> buffer)
//   cursor_col/cursor_row      : position of the next printable character
//   busy                       : clear in progress, always !in_ready
// master = byte source / observer side, slave = term_char_writer side.
interface term_char_writer_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic [7:0] w_h_addr;
  logic [7:0] w_v_addr;
  logic [5:0] w_data;
  logic       w_en;
  logic [7:0] cursor_col;
  logic [7:0] cursor_row;
  logic       busy;

  modport master (
    output in_valid, in_char,
    input  in_ready, w_h_addr, w_v_addr, w_data, w_en,
           cursor_col, cursor_row, busy
  );

  modport slave (
    input  in_valid, in_char,
    output in_ready, w_h_addr, w_v_addr, w_data, w_en,
           cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/term_char_writer.sv
// Character-stream front end for the 8x8 font terminal. Accepts ASCII bytes,
// maps printable ones to 6-bit glyphs and writes them into the character
// buffer, handling cursor advance, CR, LF, BS, line wrap and clear-screen.
//   clk, rst : clock, synchronous active-high reset
//   s_if     : byte handshake in, buffer write port and cursor/busy out
//
// state     | meaning
// IDLE      | ready for a byte
// CLEAR_ROW | writing spaces across row 0 after wrapping off the last row
// CLEAR_ALL | writing spaces over the whole screen (FF or reset)
module term_char_writer #(
  parameter int COLS           = 80,
  parameter int ROWS           = 60,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic           clk,
  input logic           rst,
  term_char_writer_if.slave s_if
);

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR_ALL : IDLE;

  state_t     r_state, w_next_state;
  logic [7:0] r_col, r_row, r_clr_col, r_clr_row;
  logic       r_clr_done, r_ready;
  logic       r_w_en;
  logic [5:0] r_w_data;
  logic [7:0] r_h_addr, r_v_addr;

  logic       w_accept, w_lower, w_printable, w_last_col, w_last_row;
  logic [7:0] w_folded;
  logic [5:0] w_glyph;

  assign w_accept    = s_if.in_valid && (r_state == IDLE);
  assign w_lower     = (s_if.in_char >= 8'h61) && (s_if.in_char <= 8'h7A);
  assign w_folded    = w_lower ? (s_if.in_char - 8'h20) : s_if.in_char;
  assign w_printable = w_lower || ((s_if.in_char >= 8'h20) && (s_if.in_char <= 8'h5F));
  assign w_glyph     = 6'(w_folded - 8'h20);
  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_row  = (r_row == LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) r_state <= RESET_STATE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:
        if (w_accept) begin
          if (s_if.in_char == 8'h0C)
            w_next_state = CLEAR_ALL;
          else if (w_last_row && ((w_printable && w_last_col) || (s_if.in_char == 8'h0A)))
            w_next_state = CLEAR_ROW;
        end
      CLEAR_ROW, CLEAR_ALL:
        // stay one cycle past the last cell so in_ready rises after it
        if (r_clr_done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  logic       d_w_en, d_clr_done;
  logic [5:0] d_w_data;
  logic [7:0] d_h_addr, d_v_addr, d_col, d_row, d_clr_col, d_clr_row;
  logic       w_emit, w_emit_all;
  logic [7:0] w_emit_col, w_emit_row;

  always_comb begin
    d_col      = r_col;
    d_row      = r_row;
    d_clr_col  = r_clr_col;
    d_clr_row  = r_clr_row;
    d_clr_done = r_clr_done;
    d_w_en     = 1'b0;
    d_w_data   = 6'd0;
    d_h_addr   = r_h_addr;
    d_v_addr   = r_v_addr;
    w_emit     = 1'b0;
    w_emit_all = 1'b0;
    w_emit_col = 8'd0;
    w_emit_row = 8'd0;
    case (r_state)
      IDLE:
        if (w_accept) begin
          if (w_printable) begin
            d_w_en   = 1'b1;
            d_w_data = w_glyph;
            d_h_addr = r_col;
            d_v_addr = r_row;
            if (!w_last_col) begin
              d_col = r_col + 8'd1;
            end else begin
              d_col = 8'd0;
              if (w_last_row) begin
                // char write occupies this cycle; row-0 clear starts next
                d_row      = 8'd0;
                d_clr_col  = 8'd0;
                d_clr_row  = 8'd0;
                d_clr_done = 1'b0;
              end else begin
                d_row = r_row + 8'd1;
              end
            end
          end else begin
            case (s_if.in_char)
              8'h0D: d_col = 8'd0;
              8'h0A: begin
                d_col = 8'd0;
                if (w_last_row) begin
                  d_row  = 8'd0;
                  w_emit = 1'b1;
                end else begin
                  d_row = r_row + 8'd1;
                end
              end
              8'h08:
                if (r_col != 8'd0) begin
                  d_col    = r_col - 8'd1;
                  d_w_en   = 1'b1;
                  d_h_addr = r_col - 8'd1;
                  d_v_addr = r_row;
                end else if (r_row != 8'd0) begin
                  d_col    = LAST_COL;
                  d_row    = r_row - 8'd1;
                  d_w_en   = 1'b1;
                  d_h_addr = LAST_COL;
                  d_v_addr = r_row - 8'd1;
                end
              8'h0C: begin
                d_col      = 8'd0;
                d_row      = 8'd0;
                w_emit     = 1'b1;
                w_emit_all = 1'b1;
              end
              default: ;
            endcase
          end
        end
      CLEAR_ROW, CLEAR_ALL:
        if (r_clr_done) begin
          d_clr_done = 1'b0;
        end else begin
          w_emit     = 1'b1;
          w_emit_col = r_clr_col;
          w_emit_row = r_clr_row;
          w_emit_all = (r_state == CLEAR_ALL);
        end
      default: ;
    endcase

    // One clear cell per cycle; LF/FF start here with cell (0,0) directly.
    if (w_emit) begin
      d_w_en     = 1'b1;
      d_w_data   = 6'd0;
      d_h_addr   = w_emit_col;
      d_v_addr   = w_emit_row;
      d_clr_done = (w_emit_col == LAST_COL) && (!w_emit_all || (w_emit_row == LAST_ROW));
      if (w_emit_col == LAST_COL) begin
        d_clr_col = 8'd0;
        d_clr_row = w_emit_row + 8'd1;
      end else begin
        d_clr_col = w_emit_col + 8'd1;
        d_clr_row = w_emit_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= 8'd0;
      r_row      <= 8'd0;
      r_clr_col  <= 8'd0;
      r_clr_row  <= 8'd0;
      r_clr_done <= 1'b0;
      r_w_en     <= 1'b0;
      r_w_data   <= 6'd0;
      r_h_addr   <= 8'd0;
      r_v_addr   <= 8'd0;
      r_ready    <= !CLEAR_ON_RESET;
    end else begin
      r_col      <= d_col;
      r_row      <= d_row;
      r_clr_col  <= d_clr_col;
      r_clr_row  <= d_clr_row;
      r_clr_done <= d_clr_done;
      r_w_en     <= d_w_en;
      r_w_data   <= d_w_data;
      r_h_addr   <= d_h_addr;
      r_v_addr   <= d_v_addr;
      r_ready    <= (w_next_state == IDLE);
    end
  end

  assign s_if.in_ready   = r_ready;
  assign s_if.busy       = ~r_ready;
  assign s_if.w_en       = r_w_en;
  assign s_if.w_data     = r_w_data;
  assign s_if.w_h_addr   = r_h_addr;
  assign s_if.w_v_addr   = r_v_addr;
  assign s_if.cursor_col = r_col;
  assign s_if.cursor_row = r_row;

endmodule

// File: tb/tb_term_char_writer.sv
// Directed bench for term_char_writer (COLS=80, ROWS=60, CLEAR_ON_RESET=1).
module tb_term_char_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  term_char_writer_if tif();

  term_char_writer #(.COLS(80), .ROWS(60), .CLEAR_ON_RESET(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (tif)
  );

  int checks = 0;
  int errors = 0;
  int cells [128][128];
  int rc_nwr, rc_nlow, rc_bad, rc_last, rc_ready;

  typedef struct {
    logic [7:0] ch;
    logic       wen;
    logic [5:0] data;
    int         h, v, col, row;
  } vec_t;
  vec_t vecs [19];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_cells();
    for (int h = 0; h < 128; h++)
      for (int v = 0; v < 128; v++) cells[h][v] = 0;
  endtask

  function automatic int bad_cells(input bit full);
    int n = 0;
    for (int h = 0; h < 128; h++)
      for (int v = 0; v < 128; v++) begin
        int e;
        e = (h < 80 && (full ? (v < 60) : (v == 0))) ? 1 : 0;
        if (cells[h][v] != e) n++;
      end
    return n;
  endfunction

  // Observe one clear at negedges until in_ready rises or budget expires.
  task automatic run_clear(input int max_cyc);
    rc_nwr = 0; rc_nlow = 0; rc_bad = 0; rc_last = -1; rc_ready = -1;
    clr_cells();
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (tif.w_en) begin
        rc_nwr++;
        if (tif.w_data !== 6'd0) rc_bad++;
        if (tif.w_h_addr < 128 && tif.w_v_addr < 128) cells[tif.w_h_addr][tif.w_v_addr]++;
        rc_last = c;
      end
      if (tif.in_ready) begin
        rc_ready = c;
        break;
      end
      rc_nlow++;
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    tif.in_valid = 1'b1;
    tif.in_char  = c;
    @(posedge clk);
    #1 tif.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_nowait(input logic [7:0] c);
    @(negedge clk);
    tif.in_valid = 1'b1;
    tif.in_char  = c;
    @(posedge clk);
    #1 tif.in_valid = 1'b0;
  endtask

  task automatic check_full_clear(input string nm);
    chk({nm, "_writes"}, rc_nwr, 4800);
    chk({nm, "_data"}, rc_bad, 0);
    chk({nm, "_cells"}, bad_cells(1'b1), 0);
    chk({nm, "_ready_idx"}, rc_ready, 4800);
    chk({nm, "_ready_after_last"}, rc_ready, rc_last + 1);
    chk({nm, "_col"}, int'(tif.cursor_col), 0);
    chk({nm, "_row"}, int'(tif.cursor_row), 0);
  endtask

  initial begin
    vecs[0]  = '{8'h41, 1'b1, 6'h21, 0, 0, 1, 0};
    vecs[1]  = '{8'h61, 1'b1, 6'h21, 1, 0, 2, 0};
    vecs[2]  = '{8'h30, 1'b1, 6'h10, 2, 0, 3, 0};
    vecs[3]  = '{8'h5F, 1'b1, 6'h3F, 3, 0, 4, 0};
    vecs[4]  = '{8'h7A, 1'b1, 6'h3A, 4, 0, 5, 0};
    vecs[5]  = '{8'h60, 1'b0, 6'h00, 0, 0, 5, 0};
    vecs[6]  = '{8'h7F, 1'b0, 6'h00, 0, 0, 5, 0};
    vecs[7]  = '{8'h01, 1'b0, 6'h00, 0, 0, 5, 0};
    vecs[8]  = '{8'h7B, 1'b0, 6'h00, 0, 0, 5, 0};
    vecs[9]  = '{8'h08, 1'b1, 6'h00, 4, 0, 4, 0};
    vecs[10] = '{8'h0A, 1'b0, 6'h00, 0, 0, 0, 1};
    vecs[11] = '{8'h20, 1'b1, 6'h00, 0, 1, 1, 1};
    vecs[12] = '{8'h0D, 1'b0, 6'h00, 0, 0, 0, 1};
    vecs[13] = '{8'h08, 1'b1, 6'h00, 79, 0, 79, 0};
    vecs[14] = '{8'h5A, 1'b1, 6'h3A, 79, 0, 0, 1};
    vecs[15] = '{8'h08, 1'b1, 6'h00, 79, 0, 79, 0};
    vecs[16] = '{8'h0D, 1'b0, 6'h00, 0, 0, 0, 0};
    vecs[17] = '{8'h08, 1'b0, 6'h00, 0, 0, 0, 0};
    vecs[18] = '{8'hFF, 1'b0, 6'h00, 0, 0, 0, 0};

    tif.in_valid = 1'b0;
    tif.in_char  = 8'h00;

    // Reset state, then the power-on clear.
    repeat (3) @(negedge clk);
    chk("rst_wen", int'(tif.w_en), 0);
    chk("rst_data", int'(tif.w_data), 0);
    chk("rst_haddr", int'(tif.w_h_addr), 0);
    chk("rst_vaddr", int'(tif.w_v_addr), 0);
    chk("rst_col", int'(tif.cursor_col), 0);
    chk("rst_row", int'(tif.cursor_row), 0);
    chk("rst_ready", int'(tif.in_ready), 0);
    chk("rst_busy", int'(tif.busy), 1);
    rst = 1'b0;
    run_clear(6000);
    check_full_clear("por");
    chk("por_busy_after", int'(tif.busy), 0);

    // Back-to-back vector table.
    for (int i = 0; i < 19; i++) begin
      tif.in_valid = 1'b1;
      tif.in_char  = vecs[i].ch;
      chk($sformatf("v%0d_ready", i), int'(tif.in_ready), 1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_wen", i), int'(tif.w_en), int'(vecs[i].wen));
      if (vecs[i].wen) begin
        chk($sformatf("v%0d_data", i), int'(tif.w_data), int'(vecs[i].data));
        chk($sformatf("v%0d_h", i), int'(tif.w_h_addr), vecs[i].h);
        chk($sformatf("v%0d_v", i), int'(tif.w_v_addr), vecs[i].v);
      end
      chk($sformatf("v%0d_col", i), int'(tif.cursor_col), vecs[i].col);
      chk($sformatf("v%0d_row", i), int'(tif.cursor_row), vecs[i].row);
    end
    tif.in_valid = 1'b0;

    // Wrap at end of a middle row: (79,10) 'Z'.
    repeat (10) send(8'h0A);
    repeat (79) send(8'h20);
    chk("pos79_10_col", int'(tif.cursor_col), 79);
    send(8'h5A);
    chk("wrapmid_wen", int'(tif.w_en), 1);
    chk("wrapmid_data", int'(tif.w_data), 'h3A);
    chk("wrapmid_h", int'(tif.w_h_addr), 79);
    chk("wrapmid_v", int'(tif.w_v_addr), 10);
    chk("wrapmid_col", int'(tif.cursor_col), 0);
    chk("wrapmid_row", int'(tif.cursor_row), 11);
    chk("wrapmid_ready", int'(tif.in_ready), 1);
    @(negedge clk);
    chk("wrapmid_noclear", int'(tif.w_en), 0);

    // Wrap-with-write at (79,59).
    repeat (48) send(8'h0A);
    repeat (79) send(8'h20);
    chk("pos79_59_row", int'(tif.cursor_row), 59);
    send(8'h21);
    chk("wrapend_wen", int'(tif.w_en), 1);
    chk("wrapend_data", int'(tif.w_data), 1);
    chk("wrapend_h", int'(tif.w_h_addr), 79);
    chk("wrapend_v", int'(tif.w_v_addr), 59);
    chk("wrapend_ready", int'(tif.in_ready), 0);
    chk("wrapend_col", int'(tif.cursor_col), 0);
    chk("wrapend_row", int'(tif.cursor_row), 0);
    run_clear(200);
    chk("wrapend_clr_writes", rc_nwr, 80);
    chk("wrapend_clr_data", rc_bad, 0);
    chk("wrapend_clr_cells", bad_cells(1'b0), 0);
    chk("wrapend_low_cycles", rc_nlow + 1, 81);
    chk("wrapend_ready_after_last", rc_ready, rc_last + 1);

    // LF on the last row.
    repeat (59) send(8'h0A);
    chk("lf59_row", int'(tif.cursor_row), 59);
    send_nowait(8'h0A);
    run_clear(200);
    chk("lfwrap_writes", rc_nwr, 80);
    chk("lfwrap_data", rc_bad, 0);
    chk("lfwrap_cells", bad_cells(1'b0), 0);
    chk("lfwrap_low_cycles", rc_nlow, 80);
    chk("lfwrap_ready_after_last", rc_ready, rc_last + 1);
    chk("lfwrap_col", int'(tif.cursor_col), 0);
    chk("lfwrap_row", int'(tif.cursor_row), 0);

    // Reset in the middle of an FF clear.
    send(8'h41);
    send_nowait(8'h0C);
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wen", int'(tif.w_en), 0);
    chk("midrst_ready", int'(tif.in_ready), 0);
    chk("midrst_busy", int'(tif.busy), 1);
    chk("midrst_col", int'(tif.cursor_col), 0);
    rst = 1'b0;
    run_clear(6000);
    check_full_clear("midrst");

    // Complete FF clear from a non-home cursor.
    send(8'h51);
    chk("ff_pre_col", int'(tif.cursor_col), 1);
    send_nowait(8'h0C);
    run_clear(6000);
    check_full_clear("ff");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
